mem_arb: RTL and testbench

- Arbitrates the core's single memory port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Sits between the ifu/lsu stages and the external memory interface, replacing the direct instruction input once loads and stores are added.
- Grants one requester at a time and latches its request, so only one memory transaction is outstanding.
- Sequences the request/response handshake with memory and routes the response back to the owner.
- Includes a starvation guard for the IFU and a response timeout.

---
 rtl/mem_arb_if.sv | 51 +++++
 rtl/mem_arb.sv | 132 +++++++++++++
 tb/tb_mem_arb.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_if.sv
// Bundle of requester (IFU/LSU) and memory-side signals for the memory arbiter.
// master is the arbiter's view; slave is the view of the surrounding core/memory.
interface mem_arb_if #(
  parameter int CPU_WIDTH = 32
);
  logic                 i_ifu_req;
  logic [CPU_WIDTH-1:0] i_ifu_addr;
  logic                 o_ifu_gnt;
  logic                 o_ifu_rvalid;
  logic [CPU_WIDTH-1:0] o_ifu_rdata;

  logic                 i_lsu_req;
  logic                 i_lsu_we;
  logic [CPU_WIDTH-1:0] i_lsu_addr;
  logic [CPU_WIDTH-1:0] i_lsu_wdata;
  logic [3:0]           i_lsu_wmask;
  logic                 o_lsu_gnt;
  logic                 o_lsu_rvalid;
  logic [CPU_WIDTH-1:0] o_lsu_rdata;

  logic                 o_mem_req;
  logic                 o_mem_we;
  logic [CPU_WIDTH-1:0] o_mem_addr;
  logic [CPU_WIDTH-1:0] o_mem_wdata;
  logic [3:0]           o_mem_wmask;
  logic                 i_mem_gnt;
  logic                 i_mem_rvalid;
  logic [CPU_WIDTH-1:0] i_mem_rdata;

  logic                 o_err;

  modport master (
    input  i_ifu_req, i_ifu_addr,
    output o_ifu_gnt, o_ifu_rvalid, o_ifu_rdata,
    input  i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_lsu_wmask,
    output o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output o_err
  );

  modport slave (
    output i_ifu_req, i_ifu_addr,
    input  o_ifu_gnt, o_ifu_rvalid, o_ifu_rdata,
    output i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_lsu_wmask,
    input  o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  o_err
  );
endinterface

// File: rtl/mem_arb.sv
// Single-outstanding memory port arbiter between IFU and LSU with an IFU
// starvation guard and a WAIT-state response timeout.
module mem_arb #(
  parameter int CPU_WIDTH  = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic      i_clk,
  input  logic      i_rst,
  mem_arb_if.master bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t               state, state_nxt;
  logic                 owner_lsu;
  logic [SW-1:0]        starve_cnt;
  logic [TW-1:0]        tmo_cnt;
  logic                 we_q;
  logic [CPU_WIDTH-1:0] addr_q, wdata_q;
  logic [3:0]           wmask_q;
  logic                 ifu_rvalid_q, lsu_rvalid_q, err_q;
  logic [CPU_WIDTH-1:0] ifu_rdata_q, lsu_rdata_q;
  logic                 ifu_win, lsu_win, tmo_hit;

  always_comb begin
    state_nxt = state;
    ifu_win   = 1'b0;
    lsu_win   = 1'b0;
    tmo_hit   = (tmo_cnt == TMO_LAST);
    unique case (state)
      IDLE: begin
        // LSU takes ties unless the IFU has been passed over STARVE_MAX times
        lsu_win = bus.i_lsu_req && !(bus.i_ifu_req && starve_cnt == STARVE_LIM);
        ifu_win = bus.i_ifu_req && !lsu_win;
        if (lsu_win || ifu_win) state_nxt = REQ;
      end
      REQ:  if (bus.i_mem_gnt) state_nxt = WAIT;
      WAIT: if (bus.i_mem_rvalid || tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      owner_lsu    <= 1'b0;
      starve_cnt   <= '0;
      tmo_cnt      <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      err_q        <= 1'b0;
      ifu_rdata_q  <= '0;
      lsu_rdata_q  <= '0;
    end else begin
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      err_q        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (lsu_win) begin
            owner_lsu <= 1'b1;
            we_q      <= bus.i_lsu_we;
            addr_q    <= bus.i_lsu_addr;
            wdata_q   <= bus.i_lsu_wdata;
            wmask_q   <= bus.i_lsu_wmask;
            if (bus.i_ifu_req && starve_cnt != STARVE_LIM)
              starve_cnt <= starve_cnt + 1'b1;
          end else if (ifu_win) begin
            owner_lsu  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= bus.i_ifu_addr;
            wdata_q    <= '0;
            wmask_q    <= '0;
            starve_cnt <= '0;
          end
        end
        REQ: if (bus.i_mem_gnt) tmo_cnt <= '0;
        WAIT: begin
          if (bus.i_mem_rvalid) begin
            if (owner_lsu) begin
              lsu_rvalid_q <= 1'b1;
              lsu_rdata_q  <= we_q ? '0 : bus.i_mem_rdata;
            end else begin
              ifu_rvalid_q <= 1'b1;
              ifu_rdata_q  <= bus.i_mem_rdata;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit) begin
              err_q <= 1'b1;
              if (owner_lsu) begin
                lsu_rvalid_q <= 1'b1;
                lsu_rdata_q  <= '0;
              end else begin
                ifu_rvalid_q <= 1'b1;
                ifu_rdata_q  <= '0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Grants are combinational so a new owner can be accepted in the rvalid cycle
  assign bus.o_ifu_gnt    = ifu_win & ~i_rst;
  assign bus.o_lsu_gnt    = lsu_win & ~i_rst;
  assign bus.o_ifu_rvalid = ifu_rvalid_q;
  assign bus.o_ifu_rdata  = ifu_rdata_q;
  assign bus.o_lsu_rvalid = lsu_rvalid_q;
  assign bus.o_lsu_rdata  = lsu_rdata_q;
  assign bus.o_mem_req    = (state == REQ);
  assign bus.o_mem_we     = we_q;
  assign bus.o_mem_addr   = addr_q;
  assign bus.o_mem_wdata  = wdata_q;
  assign bus.o_mem_wmask  = wmask_q;
  assign bus.o_err        = err_q;
endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus randomized traffic
// against a transaction-level reference model of the arbitration rules.
module tb_mem_arb;
  localparam int W          = 32;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 255;

  logic i_clk = 1'b0;
  logic i_rst;
  mem_arb_if #(.CPU_WIDTH(W)) bus();

  mem_arb #(.CPU_WIDTH(W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .bus(bus)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Stimulus knobs
  int p_ifu = 0, p_lsu = 0, p_mgnt = 100, noise_pct = 25, force_d = 0;
  bit use_fix = 0;
  logic [31:0] fix_rdata = '0;

  // Reference model: pending requests, arbiter ownership, memory schedule
  bit          ifu_pend, lsu_pend, lsu_w;
  logic [31:0] ifu_a, lsu_a, lsu_d, mem_rd;
  logic [3:0]  lsu_m;
  int          starve, phase, k, d;     // phase: 0 free, 1 request, 2 awaiting data
  bit          own_lsu, c_we;
  logic [31:0] c_addr, c_wd;
  logic [3:0]  c_m;
  bit          resp_due, resp_err, resp_lsu;
  logic [31:0] resp_data, held_ifu, held_lsu;
  int          gnt_cyc, ifu_gnt_cyc, mreq_cyc, rv_cyc, lsu_rv_cyc, n_gnt;
  bit          rv_err;
  logic [9:0]  order_bits;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    ifu_pend = 0; lsu_pend = 0; starve = 0; phase = 0; k = 0; d = 0;
    resp_due = 0; held_ifu = '0; held_lsu = '0;
  endtask

  task automatic quiet_inputs();
    bus.i_ifu_req = 0; bus.i_ifu_addr = '0; bus.i_lsu_req = 0; bus.i_lsu_we = 0;
    bus.i_lsu_addr = '0; bus.i_lsu_wdata = '0; bus.i_lsu_wmask = '0;
    bus.i_mem_gnt = 0; bus.i_mem_rvalid = 0; bus.i_mem_rdata = '0;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_ifu_gnt"},    bus.o_ifu_gnt,    0);
    check({pfx, "_ifu_rvalid"}, bus.o_ifu_rvalid, 0);
    check({pfx, "_ifu_rdata"},  bus.o_ifu_rdata,  0);
    check({pfx, "_lsu_gnt"},    bus.o_lsu_gnt,    0);
    check({pfx, "_lsu_rvalid"}, bus.o_lsu_rvalid, 0);
    check({pfx, "_lsu_rdata"},  bus.o_lsu_rdata,  0);
    check({pfx, "_mem_req"},    bus.o_mem_req,    0);
    check({pfx, "_mem_we"},     bus.o_mem_we,     0);
    check({pfx, "_mem_addr"},   bus.o_mem_addr,   0);
    check({pfx, "_mem_wdata"},  bus.o_mem_wdata,  0);
    check({pfx, "_mem_wmask"},  bus.o_mem_wmask,  0);
    check({pfx, "_err"},        bus.o_err,        0);
  endtask

  task automatic drive();
    if (!ifu_pend && $urandom_range(99) < p_ifu) begin
      ifu_pend = 1; ifu_a = $urandom;
    end
    if (!lsu_pend && $urandom_range(99) < p_lsu) begin
      lsu_pend = 1; lsu_w = 1'($urandom_range(1)); lsu_a = $urandom;
      lsu_d = $urandom; lsu_m = 4'($urandom);
    end
    bus.i_ifu_req   = ifu_pend;
    bus.i_ifu_addr  = ifu_pend ? ifu_a : $urandom;
    bus.i_lsu_req   = lsu_pend;
    bus.i_lsu_we    = lsu_pend ? lsu_w : 1'($urandom);
    bus.i_lsu_addr  = lsu_pend ? lsu_a : $urandom;
    bus.i_lsu_wdata = lsu_pend ? lsu_d : $urandom;
    bus.i_lsu_wmask = lsu_pend ? lsu_m : 4'($urandom);
    bus.i_mem_gnt   = ($urandom_range(99) < p_mgnt);
    mem_rd          = use_fix ? fix_rdata : $urandom;
    bus.i_mem_rdata = mem_rd;
    if (phase == 2) bus.i_mem_rvalid = (k == d);
    else            bus.i_mem_rvalid = ($urandom_range(99) < noise_pct);
  endtask

  task automatic sample();
    int  ph;
    bit  lw, iw;
    cyc++;
    ph = phase;
    check("ifu_rvalid", bus.o_ifu_rvalid, resp_due && !resp_lsu);
    check("lsu_rvalid", bus.o_lsu_rvalid, resp_due && resp_lsu);
    check("err",        bus.o_err,        resp_due && resp_err);
    if (resp_due) begin
      if (resp_lsu) begin held_lsu = resp_data; lsu_rv_cyc = cyc; end
      else          held_ifu = resp_data;
      rv_cyc = cyc; rv_err = bus.o_err; resp_due = 0;
    end
    check("ifu_rdata", bus.o_ifu_rdata, held_ifu);
    check("lsu_rdata", bus.o_lsu_rdata, held_lsu);
    check("mem_req",   bus.o_mem_req,   ph == 1);
    lw = 0; iw = 0;
    if (ph == 0) begin
      lw = lsu_pend && !(ifu_pend && starve == STARVE_MAX);
      iw = ifu_pend && !lw;
    end
    check("ifu_gnt", bus.o_ifu_gnt, iw);
    check("lsu_gnt", bus.o_lsu_gnt, lw);
    if (lw || iw) begin
      gnt_cyc = cyc; mreq_cyc = -1; phase = 1; n_gnt++;
      order_bits = {order_bits[8:0], lw};
      if (lw) begin
        if (ifu_pend && starve < STARVE_MAX) starve++;
        own_lsu = 1; c_we = lsu_w; c_addr = lsu_a; c_wd = lsu_d; c_m = lsu_m; lsu_pend = 0;
      end else begin
        starve = 0; ifu_gnt_cyc = cyc;
        own_lsu = 0; c_we = 0; c_addr = ifu_a; c_m = '0; ifu_pend = 0;
      end
    end
    if (ph == 1) begin
      if (mreq_cyc < 0) mreq_cyc = cyc;
      check("mem_we",    bus.o_mem_we,    c_we);
      check("mem_addr",  bus.o_mem_addr,  c_addr);
      check("mem_wmask", bus.o_mem_wmask, c_m);
      if (own_lsu) check("mem_wdata", bus.o_mem_wdata, c_wd);
      if (bus.i_mem_gnt) begin
        phase = 2; k = 0;
        d = (force_d >= 0) ? force_d : int'($urandom_range(3));
      end
    end else if (ph == 2) begin
      if (k == d) begin
        resp_due = 1; resp_lsu = own_lsu; resp_err = 0;
        resp_data = (own_lsu && c_we) ? 32'h0 : mem_rd; phase = 0;
      end else if (k == TIMEOUT - 1) begin
        resp_due = 1; resp_lsu = own_lsu; resp_err = 1; resp_data = '0; phase = 0;
      end else k++;
    end
  endtask

  task automatic step();
    @(posedge i_clk); #1;
    drive();
    @(negedge i_clk);
    sample();
  endtask

  task automatic run_until_quiet(input int maxc);
    int n = 0;
    while (!(phase == 0 && !ifu_pend && !lsu_pend && !resp_due) && n < maxc) begin
      step(); n++;
    end
    check("quiet_bound", n < maxc, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int n;
    i_rst = 1; quiet_inputs(); model_clear();
    n_gnt = 0; order_bits = '0; gnt_cyc = 0; rv_cyc = 0; mreq_cyc = 0;
    #1 check_zero("reset");
    repeat (3) @(posedge i_clk);
    @(negedge i_clk) i_rst = 0;

    // Single fetch with immediate memory grant and 1-cycle response
    p_mgnt = 100; force_d = 0; use_fix = 1; fix_rdata = 32'h00100093;
    ifu_pend = 1; ifu_a = 32'h80000000;
    run_until_quiet(20);
    check("fetch_memreq_lat", mreq_cyc - gnt_cyc, 1);
    check("fetch_rvalid_lat", rv_cyc - gnt_cyc, 3);
    check("fetch_rdata", bus.o_ifu_rdata, 32'h00100093);
    use_fix = 0;

    // Simultaneous requests: LSU first, IFU granted in LSU rvalid cycle
    ifu_pend = 1; ifu_a = 32'h80000004;
    lsu_pend = 1; lsu_w = 0; lsu_a = 32'h80001000; lsu_d = '0; lsu_m = '0;
    run_until_quiet(30);
    check("tie_order", order_bits[1:0], 2'b10);
    check("tie_regrant_cycle", ifu_gnt_cyc, lsu_rv_cyc);

    // Store: exact memory fields, zero ack data
    lsu_pend = 1; lsu_w = 1; lsu_a = 32'h80002000; lsu_d = 32'hDEADBEEF; lsu_m = 4'hF;
    run_until_quiet(20);
    check("store_rdata", bus.o_lsu_rdata, 0);

    // Starvation guard with both requesters always asserting
    p_ifu = 100; p_lsu = 100; n_gnt = 0; ifu_pend = 1; lsu_pend = 1;
    ifu_a = $urandom; lsu_w = 0; lsu_a = $urandom; lsu_d = $urandom; lsu_m = '0;
    n = 0;
    while (n_gnt < 10 && n < 200) begin step(); n++; end
    check("starve_bound", n < 200, 1);
    check("starve_order", order_bits, 10'b1111011110);
    p_ifu = 0; p_lsu = 0;
    run_until_quiet(40);

    // Timeout with no memory response, then response exactly at the limit
    force_d = 1000; ifu_pend = 1; ifu_a = $urandom;
    run_until_quiet(400);
    check("tmo_lat", rv_cyc - gnt_cyc, TIMEOUT + 2);
    check("tmo_err", rv_err, 1);
    check("tmo_rdata", bus.o_ifu_rdata, 0);
    force_d = TIMEOUT - 1; use_fix = 1; fix_rdata = 32'h12345678;
    ifu_pend = 1; ifu_a = $urandom;
    run_until_quiet(400);
    check("edge_lat", rv_cyc - gnt_cyc, TIMEOUT + 2);
    check("edge_err", rv_err, 0);
    check("edge_rdata", bus.o_ifu_rdata, 32'h12345678);
    use_fix = 0;

    // Randomized mixed traffic
    p_ifu = 35; p_lsu = 35; p_mgnt = 60; force_d = -1;
    repeat (2000) step();
    p_ifu = 0; p_lsu = 0;
    run_until_quiet(100);

    // Reset while awaiting data; late responses afterwards are ignored
    p_mgnt = 100; force_d = 1000; ifu_pend = 1; ifu_a = $urandom;
    n = 0;
    while (!(phase == 2 && k >= 3) && n < 20) begin step(); n++; end
    check("wait_reach_bound", n < 20, 1);
    @(posedge i_clk); #3;
    i_rst = 1; bus.i_ifu_req = 1; bus.i_lsu_req = 1;
    #1 check_zero("midrst");
    model_clear();
    bus.i_ifu_req = 0; bus.i_lsu_req = 0;
    @(negedge i_clk) i_rst = 0;
    noise_pct = 100;
    repeat (8) step();
    noise_pct = 25;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
